// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, one-hot select indices and opcode decode helper
package alu_pkg;

   localparam int SEL_W = 6;

   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_AND = 5'b00010;
   localparam logic [4:0] OP_OR  = 5'b00011;
   localparam logic [4:0] OP_SLL = 5'b00100;
   localparam logic [4:0] OP_SRA = 5'b00101;

   localparam int SEL_ADD = 0;
   localparam int SEL_SUB = 1;
   localparam int SEL_AND = 2;
   localparam int SEL_OR  = 3;
   localparam int SEL_SLL = 4;
   localparam int SEL_SRA = 5;

   // Skid buffer occupancy
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // Opcode to one-hot unit select; unknown opcodes give all-zero
   function automatic logic [SEL_W-1:0] decode_sel(input logic [4:0] opcode);
      logic [SEL_W-1:0] s;
      s = '0;
      case (opcode)
         OP_ADD:  s[SEL_ADD] = 1'b1;
         OP_SUB:  s[SEL_SUB] = 1'b1;
         OP_AND:  s[SEL_AND] = 1'b1;
         OP_OR:   s[SEL_OR]  = 1'b1;
         OP_SLL:  s[SEL_SLL] = 1'b1;
         OP_SRA:  s[SEL_SRA] = 1'b1;
         default: s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - upstream and ALU-side handshake bundle for the operand stage
interface alu_operand_stage_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [4:0]       ctrl_ALUopcode;
   logic [4:0]       ctrl_shiftamt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] opB_add;
   logic             cin;
   logic [SEL_W-1:0] sel;
   logic [4:0]       shamt;
   logic             illegal;
   logic [CNT_W-1:0] issued_count;

   // Environment side: issues operations and consumes results
   modport master (
      output in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
      input  in_ready, out_valid, opA, opB, opB_add, cin, sel, shamt, illegal, issued_count
   );

   // Stage side
   modport slave (
      input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
      output in_ready, out_valid, opA, opB, opB_add, cin, sel, shamt, illegal, issued_count
   );
endinterface

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - opcode to unit select, carry-in and adder operand B conditioning
module alu_op_decode
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [4:0]       i_opcode,
   input  logic [WIDTH-1:0] i_opb,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_illegal,
   output logic             o_cin,
   output logic [WIDTH-1:0] o_opb_add
);

   assign o_sel     = decode_sel(i_opcode);
   assign o_illegal = ~|o_sel;
   // SUB is done on the adder as A + ~B + 1
   assign o_cin     = (i_opcode == OP_SUB);
   assign o_opb_add = o_cin ? ~i_opb : i_opb;

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - registered 2-entry skid issue stage feeding the ALU units
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic                  clock,
   input  logic                  resetn,
   alu_operand_stage_if.slave    bus
);

   occ_e             r_occ;
   occ_e             w_occ_nxt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [CNT_W-1:0] r_cnt;

   logic             w_acc;
   logic             w_con;
   logic             w_wr_head;
   logic             w_wr_tail;
   logic             w_shift;

   logic [SEL_W-1:0] w_sel;
   logic             w_illegal;
   logic             w_cin;
   logic [WIDTH-1:0] w_opb_add;

   // Head entry drives the ALU; tail holds the skid entry
   logic [WIDTH-1:0] r_head_opa, r_head_opb, r_head_opb_add;
   logic             r_head_cin, r_head_illegal;
   logic [SEL_W-1:0] r_head_sel;
   logic [4:0]       r_head_shamt;
   logic [WIDTH-1:0] r_tail_opa, r_tail_opb, r_tail_opb_add;
   logic             r_tail_cin, r_tail_illegal;
   logic [SEL_W-1:0] r_tail_sel;
   logic [4:0]       r_tail_shamt;

   assign w_acc = bus.in_valid & r_in_ready;
   assign w_con = r_out_valid & bus.out_ready;

   alu_op_decode #(.WIDTH(WIDTH)) u_decode (
      .i_opcode  (bus.ctrl_ALUopcode),
      .i_opb     (bus.data_operandB),
      .o_sel     (w_sel),
      .o_illegal (w_illegal),
      .o_cin     (w_cin),
      .o_opb_add (w_opb_add)
   );

   // Occupancy state register with registered ready/valid derived from next occupancy
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_occ       <= OCC_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_occ       <= w_occ_nxt;
         r_in_ready  <= (w_occ_nxt != OCC_FULL);
         r_out_valid <= (w_occ_nxt != OCC_EMPTY);
      end
   end

   // Next occupancy and which storage slot is written this cycle
   always_comb begin
      w_occ_nxt = r_occ;
      w_wr_head = 1'b0;
      w_wr_tail = 1'b0;
      w_shift   = 1'b0;
      case (r_occ)
         OCC_EMPTY: begin
            if (w_acc) begin
               w_wr_head = 1'b1;
               w_occ_nxt = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (w_acc && w_con) begin
               w_wr_head = 1'b1;
            end else if (w_acc) begin
               w_wr_tail = 1'b1;
               w_occ_nxt = OCC_FULL;
            end else if (w_con) begin
               w_occ_nxt = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (w_con) begin
               w_shift   = 1'b1;
               w_occ_nxt = OCC_ONE;
            end
         end
         default: w_occ_nxt = OCC_EMPTY;
      endcase
   end

   // Head entry: refilled from the skid slot or directly from the decoded input
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_head_opa     <= '0;
         r_head_opb     <= '0;
         r_head_opb_add <= '0;
         r_head_cin     <= 1'b0;
         r_head_sel     <= '0;
         r_head_shamt   <= '0;
         r_head_illegal <= 1'b0;
      end else if (w_shift) begin
         r_head_opa     <= r_tail_opa;
         r_head_opb     <= r_tail_opb;
         r_head_opb_add <= r_tail_opb_add;
         r_head_cin     <= r_tail_cin;
         r_head_sel     <= r_tail_sel;
         r_head_shamt   <= r_tail_shamt;
         r_head_illegal <= r_tail_illegal;
      end else if (w_wr_head) begin
         r_head_opa     <= bus.data_operandA;
         r_head_opb     <= bus.data_operandB;
         r_head_opb_add <= w_opb_add;
         r_head_cin     <= w_cin;
         r_head_sel     <= w_sel;
         r_head_shamt   <= bus.ctrl_shiftamt;
         r_head_illegal <= w_illegal;
      end
   end

   // Skid entry: captures the op accepted while the head is stalled
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_tail_opa     <= '0;
         r_tail_opb     <= '0;
         r_tail_opb_add <= '0;
         r_tail_cin     <= 1'b0;
         r_tail_sel     <= '0;
         r_tail_shamt   <= '0;
         r_tail_illegal <= 1'b0;
      end else if (w_wr_tail) begin
         r_tail_opa     <= bus.data_operandA;
         r_tail_opb     <= bus.data_operandB;
         r_tail_opb_add <= w_opb_add;
         r_tail_cin     <= w_cin;
         r_tail_sel     <= w_sel;
         r_tail_shamt   <= bus.ctrl_shiftamt;
         r_tail_illegal <= w_illegal;
      end
   end

   // Count completed output handshakes, wrapping naturally
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (w_con) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.in_ready     = r_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.opA          = r_head_opa;
   assign bus.opB          = r_head_opb;
   assign bus.opB_add      = r_head_opb_add;
   assign bus.cin          = r_head_cin;
   assign bus.sel          = r_head_sel;
   assign bus.shamt        = r_head_shamt;
   assign bus.illegal      = r_head_illegal;
   assign bus.issued_count = r_cnt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

   logic clock;
   logic resetn;
   int   n_vec;
   int   n_err;

   alu_operand_stage_if #(.WIDTH(32), .CNT_W(4)) bus ();

   alu_operand_stage #(.WIDTH(32), .CNT_W(4)) u_dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
      bus.in_valid       = v;
      bus.ctrl_ALUopcode = opc;
      bus.data_operandA  = a;
      bus.data_operandB  = b;
      bus.ctrl_shiftamt  = sh;
   endtask

   task automatic drive_idle_x();
      bus.in_valid       = 1'b0;
      bus.ctrl_ALUopcode = 'x;
      bus.data_operandA  = 'x;
      bus.data_operandB  = 'x;
      bus.ctrl_shiftamt  = 'x;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bus.out_ready = 1'b0;
      drive_idle_x();
      tick(); tick();
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
      n_vec++; if (bus.sel !== 6'b0) begin n_err++; $display("FAIL rst_sel: got %b want 000000", bus.sel); end
      n_vec++; if (bus.issued_count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.issued_count); end
      resetn = 1'b1;
      tick(); tick();
      n_vec++; if (bus.opA !== 32'h0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL idle_x_leak: opA %h out_valid %b want 0/0", bus.opA, bus.out_valid); end
   endtask

   task automatic test_sub();
      bus.out_ready = 1'b1;
      drive(1'b1, 5'b00001, 32'h0000_0005, 32'h0000_0003, 5'd0);
      tick();
      drive_idle_x();
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL sub_valid: got %b want 1", bus.out_valid); end
      n_vec++; if (bus.sel !== 6'b000010) begin n_err++; $display("FAIL sub_sel: got %b want 000010", bus.sel); end
      n_vec++; if (bus.opB_add !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL sub_opb_add: got %h want fffffffc", bus.opB_add); end
      n_vec++; if (bus.cin !== 1'b1) begin n_err++; $display("FAIL sub_cin: got %b want 1", bus.cin); end
      n_vec++; if (bus.opB !== 32'h3 || bus.opA !== 32'h5) begin n_err++; $display("FAIL sub_ops: got A %h B %h want 5 3", bus.opA, bus.opB); end
      tick();
      n_vec++; if (bus.issued_count !== 4'd1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sub_count: got %0d valid %b want 1 0", bus.issued_count, bus.out_valid); end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      drive(1'b1, 5'b00010, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0);
      tick();
      n_vec++; if (bus.in_ready !== 1'b1 || bus.sel !== 6'b000100) begin n_err++; $display("FAIL bp_first: ready %b sel %b want 1 000100", bus.in_ready, bus.sel); end
      drive(1'b1, 5'b00011, 32'h0000_1111, 32'h0000_2222, 5'd0);
      tick();
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: in_ready %b want 0", bus.in_ready); end
      drive(1'b1, 5'b00000, 32'hDEAD_BEEF, 32'h1, 5'd0);
      tick(); tick();
      n_vec++; if (bus.in_ready !== 1'b0 || bus.sel !== 6'b000100 || bus.opA !== 32'h0000_F0F0) begin
         n_err++; $display("FAIL bp_hold: ready %b sel %b opA %h want 0 000100 0000f0f0", bus.in_ready, bus.sel, bus.opA);
      end
      drive_idle_x();
      bus.out_ready = 1'b1;
      tick();
      n_vec++; if (bus.sel !== 6'b001000 || bus.opA !== 32'h0000_1111 || bus.in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_second: sel %b opA %h ready %b want 001000 00001111 1", bus.sel, bus.opA, bus.in_ready);
      end
      tick();
      n_vec++; if (bus.out_valid !== 1'b0 || bus.issued_count !== 4'd3) begin
         n_err++; $display("FAIL bp_drain: valid %b count %0d want 0 3", bus.out_valid, bus.issued_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  opc;
      logic [31:0] b;
      logic [31:0] exp_add;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         opc = 5'(i % 6);
         b   = 32'(i * 3 + 1);
         drive(1'b1, opc, 32'h100 + 32'(i), b, 5'(i));
         tick();
         exp_add = (opc == 5'b00001) ? ~b : b;
         n_vec++;
         if (bus.out_valid !== 1'b1 || bus.opA !== 32'h100 + 32'(i) || bus.sel !== 6'(1 << (i % 6)) ||
             bus.opB_add !== exp_add || bus.shamt !== 5'(i) || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_%0d: valid %b opA %h sel %b opB_add %h shamt %0d ready %b", i,
                     bus.out_valid, bus.opA, bus.sel, bus.opB_add, bus.shamt, bus.in_ready);
         end
      end
      drive_idle_x();
      tick();
      n_vec++; if (bus.out_valid !== 1'b0 || bus.issued_count !== 4'd13) begin
         n_err++; $display("FAIL b2b_count: valid %b count %0d want 0 13", bus.out_valid, bus.issued_count);
      end
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b0;
      drive(1'b1, 5'b11111, 32'hA5A5_A5A5, 32'h0000_0007, 5'd3);
      tick();
      drive_idle_x();
      n_vec++; if (bus.out_valid !== 1'b1 || bus.sel !== 6'b0 || bus.illegal !== 1'b1 || bus.cin !== 1'b0) begin
         n_err++; $display("FAIL ill_head: valid %b sel %b illegal %b cin %b want 1 000000 1 0", bus.out_valid, bus.sel, bus.illegal, bus.cin);
      end
      bus.out_ready = 1'b1;
      tick();
      n_vec++; if (bus.out_valid !== 1'b0 || bus.issued_count !== 4'd14) begin
         n_err++; $display("FAIL ill_count: valid %b count %0d want 0 14", bus.out_valid, bus.issued_count);
      end
   endtask

   task automatic test_reset_midstream();
      bus.out_ready = 1'b0;
      drive(1'b1, 5'b00000, 32'h1234_5678, 32'h1, 5'd0);
      tick();
      drive(1'b1, 5'b00100, 32'h0000_00FF, 32'h2, 5'd7);
      tick();
      drive_idle_x();
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full: in_ready %b want 0", bus.in_ready); end
      #2;
      resetn = 1'b0;
      #1;
      n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sel !== 6'b0 || bus.opA !== 32'h0 ||
                   bus.issued_count !== 4'd0 || bus.illegal !== 1'b0) begin
         n_err++; $display("FAIL mid_async_rst: valid %b ready %b sel %b opA %h count %0d illegal %b",
                           bus.out_valid, bus.in_ready, bus.sel, bus.opA, bus.issued_count, bus.illegal);
      end
      tick();
      resetn = 1'b1;
      bus.out_ready = 1'b1;
      tick(); tick();
      n_vec++; if (bus.out_valid !== 1'b0 || bus.shamt !== 5'd0 || bus.issued_count !== 4'd0) begin
         n_err++; $display("FAIL mid_lost: valid %b shamt %0d count %0d want 0 0 0", bus.out_valid, bus.shamt, bus.issued_count);
      end
   endtask

   task automatic test_count_wrap();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 5'b00000, 32'(i), 32'h0, 5'd0);
         tick();
         if (i == 15) begin
            n_vec++; if (bus.issued_count !== 4'd15) begin n_err++; $display("FAIL wrap_15: got %0d want 15", bus.issued_count); end
         end
         if (i == 16) begin
            n_vec++; if (bus.issued_count !== 4'd0) begin n_err++; $display("FAIL wrap_0: got %0d want 0", bus.issued_count); end
         end
      end
      drive_idle_x();
      tick();
      n_vec++; if (bus.issued_count !== 4'd1 || bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL wrap_17: count %0d valid %b want 1 0", bus.issued_count, bus.out_valid);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_sub();
      test_backpressure();
      test_back_to_back();
      test_illegal();
      test_reset_midstream();
      test_count_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
